ps2_key_decoder: RTL

//  Upstream of the ship controller. Receives raw PS/2 keyboard frames and decodes

---
 rtl/ps2_key_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 decoder producing held-key level flags
// for the ship controller (forward / rotate / shoot).
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       forward,
    output logic       rotate_left,
    output logic       rotate_right,
    output logic       shoot,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    // held bit positions: W, Up, A, Left, D, Right, Space
    localparam int H_W = 0, H_UP = 1, H_A = 2, H_LEFT = 3, H_D = 4, H_RIGHT = 5, H_SPACE = 6;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev;
    logic                   fall_p0;
    logic [10:0]            shift_p0;
    logic [3:0]             bit_cnt;
    logic [WD_W-1:0]        wd_cnt;
    logic                   timeout;
    logic                   vld_p1;
    state_t                 state_q, state_nxt;
    logic [6:0]             held_q, held_nxt;

    function automatic logic frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    endfunction

    function automatic logic [6:0] base_mask(input logic [7:0] c);
        logic [6:0] m;
        m = '0;
        case (c)
            8'h1D: m[H_W]     = 1'b1;
            8'h1C: m[H_A]     = 1'b1;
            8'h23: m[H_D]     = 1'b1;
            8'h29: m[H_SPACE] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [6:0] ext_mask(input logic [7:0] c);
        logic [6:0] m;
        m = '0;
        case (c)
            8'h75: m[H_UP]    = 1'b1;
            8'h6B: m[H_LEFT]  = 1'b1;
            8'h74: m[H_RIGHT] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    assign fall_p0 = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign timeout = (bit_cnt != 4'd0) && !fall_p0 &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // stage p0: synchronise pins, detect falls, count bits, watchdog
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync   <= '1;
            dat_sync   <= '1;
            clk_prev   <= 1'b1;
            bit_cnt    <= 4'd0;
            wd_cnt     <= '0;
            vld_p1     <= 1'b0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync   <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            vld_p1     <= 1'b0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (fall_p0) begin
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                    vld_p1  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (timeout) begin
                bit_cnt   <= 4'd0;
                frame_err <= 1'b1;
            end

            if (fall_p0 || bit_cnt == 4'd0 || timeout)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WD_W'(1);

            // stage p1: frame check on the completed shift register
            if (vld_p1) begin
                if (frame_ok(shift_p0)) begin
                    scan_code  <= shift_p0[8:1];
                    scan_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fall_p0)
            shift_p0 <= {dat_sync[SYNC_STAGES-1], shift_p0[10:1]};
    end

    // stage p2: prefix-tracking decode of the byte in the scan_valid cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_nxt;
            held_q  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        held_nxt  = held_q;
        if (scan_valid) begin
            state_nxt = IDLE;
            case (state_q)
                IDLE: begin
                    if (scan_code == 8'hE0)      state_nxt = EXT;
                    else if (scan_code == 8'hF0) state_nxt = BRK;
                    else if (scan_code == 8'hAA) held_nxt  = '0;
                    else                         held_nxt  = held_q | base_mask(scan_code);
                end
                EXT: begin
                    if (scan_code == 8'hF0) state_nxt = EXT_BRK;
                    else                    held_nxt  = held_q | ext_mask(scan_code);
                end
                BRK:     held_nxt = held_q & ~base_mask(scan_code);
                EXT_BRK: held_nxt = held_q & ~ext_mask(scan_code);
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign forward      = held_q[H_W] | held_q[H_UP];
    assign rotate_left  = held_q[H_A] | held_q[H_LEFT];
    assign rotate_right = held_q[H_D] | held_q[H_RIGHT];
    assign shoot        = held_q[H_SPACE];

endmodule
